// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch channel: request/address out, ready/data back.
// Latency: the response is same-cycle; data is valid for addr in the cycle ready=1.
// Backpressure: memory stalls the fetcher by holding ready low.
//   req   : fetch request (fetcher -> memory)
//   addr  : fetch address (fetcher -> memory)
//   ready : response present this cycle (memory -> fetcher)
//   data  : instruction word (memory -> fetcher)
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] data;

  modport master (output req, output addr, input ready, input data);
  modport slave  (input req, input addr, output ready, output data);
endinterface

// File: rtl/fetch_stage.sv
// IF stage: PC register, IF/ID register and a one-entry hold buffer for stalls.
// Latency: an instruction lands in IF/ID one edge after its ready cycle.
// Backpressure: stall_i freezes PC/IF/ID; a fetch completing while stalled is parked in buf.
// Ports: clk_i/rst_i (async active-low) | start_i, stall_i, flush_i, target_i control
//        imem (master modport) | inst_o, pc4_o, valid_o = IF/ID | stall_cnt_o counter
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [31:0]      target_i,
  fetch_stage_if.master    imem,
  output logic [31:0]      inst_o,
  output logic [31:0]      pc4_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [31:0]      buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;  // wraps modulo 2^32

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;

    if (stall_i && (state_q != ST_IDLE) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (flush_i) begin
          // Redirect; any response arriving this cycle belongs to the wrong path.
          pc_d    = target_i;
          inst_d  = 32'h0;
          pc4_d   = 32'h0;
          valid_d = 1'b0;
        end else if (stall_i) begin
          // Park a completing fetch so it is not lost while ID is frozen.
          if (imem.ready) begin
            buf_d   = imem.data;
            state_d = ST_HOLD;
          end
        end else if (imem.ready) begin
          inst_d  = imem.data;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
        end else begin
          // Memory wait state: feed a bubble, keep pc4 as it was.
          inst_d  = 32'h0;
          valid_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (flush_i) begin
          pc_d    = target_i;
          inst_d  = 32'h0;
          pc4_d   = 32'h0;
          valid_d = 1'b0;
          state_d = ST_REQ;
        end else if (!stall_i) begin
          // buf holds the word fetched from pc, so pc has not advanced yet.
          inst_d  = buf_q;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
      buf_q   <= 32'h0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem.req    = (state_q == ST_REQ);
  assign imem.addr   = pc_q;
  assign inst_o      = inst_q;
  assign pc4_o       = pc4_q;
  assign valid_o     = valid_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: two instances (default, and wrap/4-bit counter).
// Memory model answers same-cycle with addr | 32'h1000.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Main instance, RESET_PC = 0, CNT_W = 16
  logic        rst_n, start, stall, flush, rdy;
  logic [31:0] target;
  logic [31:0] inst, pc4;
  logic        valid;
  logic [15:0] cnt;
  fetch_stage_if mif ();
  assign mif.ready = rdy;
  assign mif.data  = mif.addr | 32'h1000;

  fetch_stage dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall), .flush_i(flush),
    .target_i(target), .imem(mif), .inst_o(inst), .pc4_o(pc4), .valid_o(valid),
    .stall_cnt_o(cnt)
  );

  // Second instance: PC wrap and counter saturation
  logic        rst2_n, start2, stall2;
  logic [31:0] inst2, pc42;
  logic        valid2;
  logic [3:0]  cnt2;
  fetch_stage_if mif2 ();
  assign mif2.ready = 1'b1;
  assign mif2.data  = mif2.addr | 32'h1000;

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(4)) dut2 (
    .clk_i(clk), .rst_i(rst2_n), .start_i(start2), .stall_i(stall2), .flush_i(1'b0),
    .target_i(32'h0), .imem(mif2), .inst_o(inst2), .pc4_o(pc42), .valid_o(valid2),
    .stall_cnt_o(cnt2)
  );

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0; rdy = 1'b1; target = 32'h0;
    rst2_n = 1'b0; start2 = 1'b0; stall2 = 1'b0;

    #2;
    chk("rst_req",   {31'b0, mif.req}, 32'h0);
    chk("rst_addr",  mif.addr, 32'h0);
    chk("rst_inst",  inst, 32'h0);
    chk("rst_pc4",   pc4, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_cnt",   {16'b0, cnt}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    step();  // idle, start still low
    chk("idle_req", {31'b0, mif.req}, 32'h0);
    start = 1'b1;
    step();
    chk("e1_req",   {31'b0, mif.req}, 32'h1);
    chk("e1_addr",  mif.addr, 32'h0);
    chk("e1_valid", {31'b0, valid}, 32'h0);
    step();
    chk("e2_inst",  inst, 32'h1000);
    chk("e2_pc4",   pc4, 32'h4);
    chk("e2_valid", {31'b0, valid}, 32'h1);
    chk("e2_addr",  mif.addr, 32'h4);
    step();
    chk("e3_inst",  inst, 32'h1004);
    chk("e3_pc4",   pc4, 32'h8);
    chk("e3_addr",  mif.addr, 32'h8);

    // Load-use stall with ready at addr 8: word parked in buf
    stall = 1'b1;
    step();
    chk("st_inst",  inst, 32'h1004);
    chk("st_pc4",   pc4, 32'h8);
    chk("st_req",   {31'b0, mif.req}, 32'h0);
    chk("st_addr",  mif.addr, 32'h8);
    chk("st_cnt",   {16'b0, cnt}, 32'h1);
    stall = 1'b0;
    step();
    chk("buf_inst", inst, 32'h1008);
    chk("buf_pc4",  pc4, 32'hC);
    chk("buf_req",  {31'b0, mif.req}, 32'h1);
    chk("buf_addr", mif.addr, 32'hC);

    // Stall into HOLD, then flush while still stalled
    stall = 1'b1;
    step();
    chk("h_req", {31'b0, mif.req}, 32'h0);
    flush = 1'b1; target = 32'h40;
    step();
    chk("fl_valid", {31'b0, valid}, 32'h0);
    chk("fl_inst",  inst, 32'h0);
    chk("fl_addr",  mif.addr, 32'h40);
    chk("fl_req",   {31'b0, mif.req}, 32'h1);
    chk("fl_cnt",   {16'b0, cnt}, 32'h3);
    flush = 1'b0; stall = 1'b0;
    step();
    chk("tg_inst", inst, 32'h1040);
    chk("tg_pc4",  pc4, 32'h44);

    // Flush in REQ to addr 16 (response this cycle discarded), then wait states
    flush = 1'b1; target = 32'h10;
    step();
    chk("fr_valid", {31'b0, valid}, 32'h0);
    chk("fr_addr",  mif.addr, 32'h10);
    flush = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ws_valid", {31'b0, valid}, 32'h0);
      chk("ws_addr",  mif.addr, 32'h10);
      chk("ws_pc4",   pc4, 32'h0);
    end
    rdy = 1'b1;
    step();
    chk("ws_inst", inst, 32'h1010);
    chk("ws_pc4b", pc4, 32'h14);

    // Stall with no response: everything holds
    rdy = 1'b0; stall = 1'b1;
    step();
    chk("sh_inst",  inst, 32'h1010);
    chk("sh_valid", {31'b0, valid}, 32'h1);
    chk("sh_addr",  mif.addr, 32'h14);
    chk("sh_req",   {31'b0, mif.req}, 32'h1);
    chk("sh_cnt",   {16'b0, cnt}, 32'h4);

    // Asynchronous reset pulse, not clock aligned
    stall = 1'b0; rdy = 1'b1; start = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_req",   {31'b0, mif.req}, 32'h0);
    chk("ar_inst",  inst, 32'h0);
    chk("ar_valid", {31'b0, valid}, 32'h0);
    chk("ar_pc4",   pc4, 32'h0);
    chk("ar_addr",  mif.addr, 32'h0);
    chk("ar_cnt",   {16'b0, cnt}, 32'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ar_idle_req", {31'b0, mif.req}, 32'h0);
    end
    start = 1'b1;
    step();
    chk("rs_req",  {31'b0, mif.req}, 32'h1);
    chk("rs_addr", mif.addr, 32'h0);
    step();
    chk("rs_inst", inst, 32'h1000);

    // Wrap and saturation on the second instance
    rst2_n = 1'b1; start2 = 1'b1;
    step();
    chk("w_addr0", mif2.addr, 32'hFFFF_FFFC);
    step();
    chk("w_addr1", mif2.addr, 32'h0);
    chk("w_pc4",   pc42, 32'h0);
    chk("w_inst",  inst2, 32'hFFFF_FFFC);
    chk("w_valid", {31'b0, valid2}, 32'h1);
    stall2 = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt", {28'b0, cnt2}, 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
